alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_seq.sv | 50 +++++
 rtl/alu_seq.sv | 116 +++++++++++
 tb/tb_alu_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: op codes, FSM state encoding and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int N = 3;
  localparam int V = 2;
  localparam int C = 1;
  localparam int Z = 0;

  function automatic logic [3:0] pack_flags(input logic n_bit, input logic v_bit,
                                            input logic c_bit, input logic z_bit);
    logic [3:0] f;
    f    = '0;
    f[N] = n_bit;
    f[V] = v_bit;
    f[C] = c_bit;
    f[Z] = z_bit;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, W cycles per operation.
module alu_mul_seq #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   product,
  output logic             done
);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           active;
  logic [2*W-1:0] addend;

  // product and done describe the step happening this cycle, so the caller can
  // capture the final product on the same edge as the last step.
  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;
  assign done    = active && (cnt == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, status flags and an iterative multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   y,
  output logic [3:0]       flags
);

  logic [1:0]     state;
  logic           accept;
  logic           mul_start;
  logic [2*W-1:0] mul_product;
  logic           mul_done;
  logic [3:0]     mul_flags;

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] op_y;
  logic [3:0]     op_flags;
  logic           op_c;
  logic           op_v;

  // in_ready is forced low while reset is held so nothing is accepted during reset.
  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (s == OP_MUL);

  alu_mul_seq #(.W(W), .CW(CW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .product (mul_product),
    .done    (mul_done)
  );

  assign mul_flags = pack_flags(mul_product[2*W-1], 1'b0, 1'b0, mul_product == '0);

  // SUB keeps the true difference: the W+1-bit result is sign-extended, so its
  // top bit doubles as the borrow.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    op_y = '0;
    op_c = 1'b0;
    op_v = 1'b0;
    case (s)
      OP_ADD: begin
        op_y = {{(W-1){1'b0}}, sum};
        op_c = sum[W];
        op_v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        op_y = {{(W-1){diff[W]}}, diff};
        op_c = diff[W];
        op_v = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_AND: op_y[W-1:0] = a & b;
      OP_OR:  op_y[W-1:0] = a | b;
      OP_XOR: op_y[W-1:0] = a ^ b;
      OP_NOT: op_y[W-1:0] = ~a;
      OP_CMP: op_y[2:0]   = {a > b, a == b, a < b};
      default: op_y = '0;
    endcase
    op_flags = pack_flags(op_y[2*W-1], op_v, op_c, op_y == '0);
  end

  // DONE with out_ready behaves like IDLE for a new op, giving full-rate
  // back-to-back single-cycle ops; y and flags only move when a result lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      y     <= '0;
      flags <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (s == OP_MUL) begin
              state <= BUSY;
            end else begin
              y     <= op_y;
              flags <= op_flags;
              state <= DONE;
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (mul_done) begin
            y     <= mul_product;
            flags <= mul_flags;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases with literal expectations plus random traffic against a reference model.
module tb_alu_seq;

  localparam int W    = 4;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, AND = 3'd3,
                         OR  = 3'd4, XOR = 3'd5, NOT = 3'd6, CMP = 3'd7;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2:0]     s = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] y;
  logic [3:0]     flags;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  // Reference model: a result is either on display, or a multiply is counting down.
  bit             m_hold = 1'b0;
  int             m_wait = 0;
  logic [2*W-1:0] m_y = '0;
  logic [3:0]     m_flags = '0;
  logic [2*W-1:0] m_pend_y = '0;
  logic [3:0]     m_pend_flags = '0;

  function automatic bit model_ready();
    return !rst && (m_wait == 0) && (!m_hold || out_ready);
  endfunction

  function automatic void ref_op(input logic [2:0] op, input int ua, input int ub,
                                 output logic [2*W-1:0] ry, output logic [3:0] rf);
    int r, sa, sb, sr;
    bit cf, vf;
    sa = (ua >= HALF) ? ua - MOD : ua;
    sb = (ub >= HALF) ? ub - MOD : ub;
    cf = 1'b0;
    vf = 1'b0;
    r  = 0;
    case (op)
      ADD: begin r = ua + ub; cf = (r >= MOD); sr = sa + sb; vf = (sr > HALF - 1) || (sr < -HALF); end
      SUB: begin r = ua - ub; cf = (ua < ub);  sr = sa - sb; vf = (sr > HALF - 1) || (sr < -HALF); end
      MUL: r = ua * ub;
      AND: r = ua & ub;
      OR:  r = ua | ub;
      XOR: r = ua ^ ub;
      NOT: r = MOD - 1 - ua;
      default: r = (ua > ub) ? 4 : ((ua == ub) ? 2 : 1);
    endcase
    r  = r & (MOD * MOD - 1);
    ry = (2*W)'(r);
    rf = {ry[2*W-1], vf, cf, r == 0};
  endfunction

  always @(posedge clk or posedge rst) begin
    bit             acc;
    logic [2*W-1:0] ry;
    logic [3:0]     rf;
    if (rst) begin
      m_hold  = 1'b0;
      m_wait  = 0;
      m_y     = '0;
      m_flags = '0;
    end else begin
      acc = in_valid && model_ready();
      if (m_hold && out_ready) m_hold = 1'b0;
      if (m_wait > 0) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_hold  = 1'b1;
          m_y     = m_pend_y;
          m_flags = m_pend_flags;
        end
      end
      if (acc) begin
        ref_op(s, int'(a), int'(b), ry, rf);
        if (s == MUL) begin
          m_wait       = W;
          m_pend_y     = ry;
          m_pend_flags = rf;
        end else begin
          m_hold  = 1'b1;
          m_y     = ry;
          m_flags = rf;
        end
      end
    end
  end

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      compare("model_out_valid", 16'(out_valid), 16'(m_hold));
      compare("model_in_ready",  16'(in_ready),  16'(model_ready()));
      compare("model_y",         16'(y),         16'(m_y));
      compare("model_flags",     16'(flags),     16'(m_flags));
    end
  end

  task automatic applyStimulus(input bit v, input logic [2:0] op, input logic [W-1:0] aa,
                               input logic [W-1:0] bb, input bit ordy);
    in_valid  = v;
    s         = op;
    a         = aa;
    b         = bb;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input bit ev, input bit er,
                             input logic [2*W-1:0] ey, input logic [3:0] ef);
    compare({name, "_valid"}, 16'(out_valid), 16'(ev));
    compare({name, "_ready"}, 16'(in_ready),  16'(er));
    compare({name, "_y"},     16'(y),         16'(ey));
    compare({name, "_flags"}, 16'(flags),     16'(ef));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [2*W-1:0] ey, input logic [3:0] ef);
    applyStimulus(1'b1, op, aa, bb, 1'b1);
    tick();
    applyStimulus(1'b0, op, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput(name, 1'b1, 1'b1, ey, ef);
    tick();
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]     b2b_ops [4];
    logic [2*W-1:0] b2b_exp [4];
    int             lat;

    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset", 1'b0, 1'b0, 8'h00, 4'b0000);
    checking = 1'b1;
    tick();
    rst = 1'b0;

    runOp("add_9_3",  ADD, 4'd9,  4'd3,  8'h0C, 4'b0000);
    runOp("add_15_1", ADD, 4'd15, 4'd1,  8'h10, 4'b0010);
    runOp("sub_9_11", SUB, 4'd9,  4'd11, 8'hFE, 4'b1010);
    runOp("sub_7_8",  SUB, 4'd7,  4'd8,  8'hFF, 4'b1110);

    // Multiply 13x11: busy for W cycles, result visible W+1 cycles after accept.
    applyStimulus(1'b1, MUL, 4'd13, 4'd11, 1'b1);
    tick();
    applyStimulus(1'b0, MUL, '0, '0, 1'b1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checkOutput("mul_busy", 1'b0, 1'b0, 8'hFF, 4'b1110);
      tick();
    end
    @(negedge clk);
    checkOutput("mul_13_11", 1'b1, 1'b1, 8'h8F, 4'b1000);
    tick();

    applyStimulus(1'b1, MUL, 4'd0, 4'd9, 1'b1);
    tick();
    applyStimulus(1'b0, MUL, '0, '0, 1'b1);
    lat = 1;
    while (lat <= 2 * W + 2) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      tick();
      lat++;
    end
    compare("mul_0_9_latency", 16'(lat), 16'(W + 1));
    checkOutput("mul_0_9", 1'b1, 1'b1, 8'h00, 4'b0001);
    tick();

    // Backpressure: the XOR result must sit still while the consumer stalls.
    applyStimulus(1'b1, XOR, 4'd10, 4'd11, 1'b0);
    tick();
    applyStimulus(1'b0, XOR, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("xor_hold", 1'b1, 1'b0, 8'h01, 4'b0000);
      tick();
    end
    applyStimulus(1'b1, CMP, 4'd5, 4'd11, 1'b1);
    @(negedge clk);
    checkOutput("xor_release", 1'b1, 1'b1, 8'h01, 4'b0000);
    tick();
    applyStimulus(1'b0, CMP, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("cmp_5_11", 1'b1, 1'b1, 8'h01, 4'b0000);
    tick();

    b2b_ops = '{AND, OR, NOT, CMP};
    b2b_exp = '{8'h08, 8'h0E, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, b2b_ops[i], 4'd12, 4'd10, 1'b1);
      if (i > 0) begin
        @(negedge clk);
        checkOutput($sformatf("b2b_%0d", i - 1), 1'b1, 1'b1, b2b_exp[i-1], 4'b0000);
      end
      tick();
    end
    applyStimulus(1'b0, AND, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("b2b_3", 1'b1, 1'b1, b2b_exp[3], 4'b0000);
    tick();

    // Reset two cycles into a multiply discards it entirely.
    applyStimulus(1'b1, MUL, 4'd13, 4'd11, 1'b1);
    tick();
    applyStimulus(1'b0, MUL, '0, '0, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_mul", 1'b0, 1'b0, 8'h00, 4'b0000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_idle", 1'b0, 1'b1, 8'h00, 4'b0000);
      tick();
    end
    runOp("add_1_1", ADD, 4'd1, 4'd1, 8'h02, 4'b0000);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                    W'($urandom_range(0, MOD - 1)), W'($urandom_range(0, MOD - 1)),
                    $urandom_range(0, 3) != 0);
      tick();
    end
    applyStimulus(1'b0, ADD, '0, '0, 1'b1);
    for (int i = 0; i < W + 2; i++) tick();
    checking = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
